// File: rtl/chacha_block_sequencer.sv
// chacha_block_sequencer
//
// Runs the ChaCha20 block function for a run of consecutive keystream blocks.
// When a job is accepted, the 16-word initial state is built from the
// constants, the key, the block counter and the nonce. The working state goes
// to an external combinational double-round unit for NUM_DR cycles. The
// initial state is then added word-wise to the result, and the 512-bit
// keystream block is presented on a valid/ready interface. After each block
// the counter is incremented, until the requested number of blocks is done.
// The counter never wraps: a job that would wrap is cut short and flagged.
//
// Ports
//   clk, reset_n      clock, synchronous active-low reset
//   start             job request, accepted only in IDLE
//   key, nonce        256-bit key and 96-bit nonce, word i at [32*i+:32]
//   counter_init      block counter of the first block
//   num_blocks        number of blocks to produce (0 = finish at once)
//   abort             cancel the current job, return to IDLE
//   dr_state_o        working state to the double-round unit
//   dr_state_i        double-round result of dr_state_o, same cycle
//   ks_valid/ks_ready keystream handshake
//   ks_data           keystream block, word i at [32*i+:32]
//   ks_counter        block counter used for ks_data
//   busy              high in every state except IDLE
//   done              one-cycle pulse when the job finishes
//   err_wrap          one-cycle pulse with done when the counter would wrap
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for start
// S_ROUND | one double round per cycle; round_left counts down to 0
// S_OUT   | keystream block held on ks_data until the handshake
// S_DONE  | done (and possibly err_wrap) pulse, then IDLE

module chacha_block_sequencer #(
  parameter int NUM_DR = 10,
  parameter int BLK_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [255:0]      key,
  input  logic [95:0]       nonce,
  input  logic [31:0]       counter_init,
  input  logic [BLK_W-1:0]  num_blocks,
  input  logic              abort,
  output logic [511:0]      dr_state_o,
  input  logic [511:0]      dr_state_i,
  output logic              ks_valid,
  input  logic              ks_ready,
  output logic [511:0]      ks_data,
  output logic [31:0]       ks_counter,
  output logic              busy,
  output logic              done,
  output logic              err_wrap
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ROUND,
    S_OUT,
    S_DONE
  } state_t;

  localparam logic [3:0]  RND_LAST = 4'(NUM_DR - 1);
  localparam logic [31:0] CTR_MAX  = 32'hFFFF_FFFF;

  state_t           state_q, state_d;
  logic [511:0]     working_q;
  logic [511:0]     init_q;
  logic [511:0]     ks_data_q;
  logic [31:0]      ks_counter_q;
  logic [BLK_W-1:0] blocks_left_q;
  logic [3:0]       round_left_q;
  logic             wrap_q;

  logic             load_first;
  logic             load_next;
  logic             set_wrap;
  logic             last_round;
  logic [31:0]      ctr_cur;
  logic [511:0]     init_first;
  logic [511:0]     init_next;
  logic [511:0]     ks_sum;

  function automatic logic [511:0] build_state(
    input logic [255:0] k,
    input logic [95:0]  n,
    input logic [31:0]  c
  );
    logic [511:0] s;
    s[0   +: 32]  = 32'h6170_7865;
    s[32  +: 32]  = 32'h3320_646e;
    s[64  +: 32]  = 32'h7962_2d32;
    s[96  +: 32]  = 32'h6b20_6574;
    s[128 +: 256] = k;
    s[384 +: 32]  = c;
    s[416 +: 96]  = n;
    return s;
  endfunction

  // Sixteen independent 32-bit adds; carries must not cross word boundaries.
  function automatic logic [511:0] add_words(
    input logic [511:0] a,
    input logic [511:0] b
  );
    logic [511:0] r;
    for (int i = 0; i < 16; i++) begin
      r[32*i +: 32] = a[32*i +: 32] + b[32*i +: 32];
    end
    return r;
  endfunction

  // The block counter lives in word 12 of the initial state.
  assign ctr_cur    = init_q[384 +: 32];
  assign init_first = build_state(key, nonce, counter_init);
  assign init_next  = {init_q[511:416], ctr_cur + 32'd1, init_q[383:0]};
  assign ks_sum     = add_words(dr_state_i, init_q);
  assign last_round = (round_left_q == 4'd0);

  always_comb begin
    state_d    = state_q;
    load_first = 1'b0;
    load_next  = 1'b0;
    set_wrap   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (num_blocks != '0) begin
            state_d    = S_ROUND;
            load_first = 1'b1;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_ROUND: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (last_round) begin
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        // abort wins over a handshake in the same cycle
        if (abort) begin
          state_d = S_IDLE;
        end else if (ks_ready) begin
          if (blocks_left_q == BLK_W'(1)) begin
            state_d = S_DONE;
          end else if (ctr_cur == CTR_MAX) begin
            state_d  = S_DONE;
            set_wrap = 1'b1;
          end else begin
            state_d   = S_ROUND;
            load_next = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      working_q     <= '0;
      init_q        <= '0;
      ks_data_q     <= '0;
      ks_counter_q  <= '0;
      blocks_left_q <= '0;
      round_left_q  <= '0;
      wrap_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      // wrap_q is set only on the edge into S_DONE, so it is high exactly
      // for the done cycle
      wrap_q  <= set_wrap;
      if (load_first) begin
        init_q        <= init_first;
        working_q     <= init_first;
        blocks_left_q <= num_blocks;
        round_left_q  <= RND_LAST;
      end else if (load_next) begin
        init_q        <= init_next;
        working_q     <= init_next;
        blocks_left_q <= blocks_left_q - BLK_W'(1);
        round_left_q  <= RND_LAST;
      end else if (state_q == S_ROUND && !abort) begin
        working_q <= dr_state_i;
        if (last_round) begin
          ks_data_q    <= ks_sum;
          ks_counter_q <= ctr_cur;
        end else begin
          round_left_q <= round_left_q - 4'd1;
        end
      end
    end
  end

  assign dr_state_o = working_q;
  assign ks_valid   = (state_q == S_OUT);
  assign ks_data    = ks_data_q;
  assign ks_counter = ks_counter_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign err_wrap   = (state_q == S_DONE) && wrap_q;

endmodule

// File: tb/tb_chacha_block_sequencer.sv
// Testbench for chacha_block_sequencer. Provides the combinational
// double-round unit and a whole-block ChaCha20 reference model.
module tb_chacha_block_sequencer;

  localparam int NUM_DR = 10;
  localparam int BLK_W  = 16;
  localparam int PERIOD = NUM_DR + 1;

  logic             clk;
  logic             reset_n;
  logic             start;
  logic [255:0]     key;
  logic [95:0]      nonce;
  logic [31:0]      counter_init;
  logic [BLK_W-1:0] num_blocks;
  logic             abort;
  logic [511:0]     dr_state_o;
  logic [511:0]     dr_state_i;
  logic             ks_valid;
  logic             ks_ready;
  logic [511:0]     ks_data;
  logic [31:0]      ks_counter;
  logic             busy;
  logic             done;
  logic             err_wrap;

  int n_cmp = 0;
  int n_bad = 0;

  int           obs_nblk;
  int           obs_done;
  int           obs_err;
  int           obs_err_alone;
  int           obs_unstable;
  int           obs_first_valid;
  int           obs_valid_cycles;
  int           obs_gap;
  int           obs_timeout;
  logic         obs_busy1;
  logic [31:0]  obs_ctr[16];
  logic [511:0] obs_data[16];
  int           obs_cyc[16];

  chacha_block_sequencer #(.NUM_DR(NUM_DR), .BLK_W(BLK_W)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .key(key),
    .nonce(nonce),
    .counter_init(counter_init),
    .num_blocks(num_blocks),
    .abort(abort),
    .dr_state_o(dr_state_o),
    .dr_state_i(dr_state_i),
    .ks_valid(ks_valid),
    .ks_ready(ks_ready),
    .ks_data(ks_data),
    .ks_counter(ks_counter),
    .busy(busy),
    .done(done),
    .err_wrap(err_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [127:0] qr(input logic [31:0] a_in, b_in, c_in, d_in);
    logic [31:0] a, b, c, d;
    a = a_in; b = b_in; c = c_in; d = d_in;
    a = a + b; d = rotl(d ^ a, 16);
    c = c + d; b = rotl(b ^ c, 12);
    a = a + b; d = rotl(d ^ a, 8);
    c = c + d; b = rotl(b ^ c, 7);
    return {a, b, c, d};
  endfunction

  function automatic logic [511:0] double_round(input logic [511:0] s);
    logic [31:0]  x[16];
    logic [511:0] r;
    for (int i = 0; i < 16; i++) x[i] = s[32*i +: 32];
    for (int c = 0; c < 4; c++)
      {x[c], x[c+4], x[c+8], x[c+12]} = qr(x[c], x[c+4], x[c+8], x[c+12]);
    for (int c = 0; c < 4; c++)
      {x[c], x[4+(c+1)%4], x[8+(c+2)%4], x[12+(c+3)%4]} =
        qr(x[c], x[4+(c+1)%4], x[8+(c+2)%4], x[12+(c+3)%4]);
    for (int i = 0; i < 16; i++) r[32*i +: 32] = x[i];
    return r;
  endfunction

  // Stand-in for the external double-round datapath.
  always_comb dr_state_i = double_round(dr_state_o);

  function automatic logic [511:0] ref_block(input logic [255:0] k, input logic [95:0] n,
                                             input logic [31:0] c);
    logic [511:0] init, s, r;
    init = {n, c, k, 32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};
    s = init;
    for (int i = 0; i < NUM_DR; i++) s = double_round(s);
    for (int i = 0; i < 16; i++) r[32*i +: 32] = s[32*i +: 32] + init[32*i +: 32];
    return r;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [95:0] rand96();
    return {$urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one job. The accept cycle is cycle 0; cycle k is the cycle after
  // the k-th edge following it. With poke set, start is re-asserted with
  // scrambled inputs for five cycles while the job is busy.
  task automatic drive_job(input logic [255:0] k, input logic [95:0] n, input logic [31:0] c,
                           input logic [BLK_W-1:0] nb, input bit random_ready, input bit poke);
    int           hs_cyc;
    bit           held;
    bit           fin;
    logic [511:0] prev_d;
    logic [31:0]  prev_c;
    obs_nblk = 0; obs_done = 0; obs_err = 0; obs_err_alone = 0; obs_unstable = 0;
    obs_first_valid = -1; obs_valid_cycles = 0; obs_gap = -1; obs_timeout = 0;
    hs_cyc = 0; held = 0; fin = 0; prev_d = '0; prev_c = '0;
    key = k; nonce = n; counter_init = c; num_blocks = nb; ks_ready = 1'b0; start = 1'b1;
    tick();
    obs_busy1 = busy;
    for (int cyc = 1; cyc <= 600 && !fin; cyc++) begin
      if (poke && cyc <= 5) begin
        start = 1'b1; key = rand256(); nonce = rand96();
        counter_init = $urandom; num_blocks = BLK_W'($urandom);
      end else begin
        start = 1'b0;
      end
      if (done) begin
        obs_done++;
        obs_gap = cyc - hs_cyc;
        if (err_wrap) obs_err++;
      end else if (err_wrap) begin
        obs_err_alone++;
      end
      if (ks_valid) begin
        obs_valid_cycles++;
        if (obs_first_valid < 0) obs_first_valid = cyc;
        if (held && (ks_data !== prev_d || ks_counter !== prev_c)) obs_unstable++;
        prev_d = ks_data;
        prev_c = ks_counter;
      end
      if (obs_done > 0 && !busy) begin
        fin = 1;
      end else begin
        ks_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        held = ks_valid && !ks_ready;
        if (ks_valid && ks_ready) begin
          if (obs_nblk < 16) begin
            obs_ctr[obs_nblk]  = ks_counter;
            obs_data[obs_nblk] = ks_data;
            obs_cyc[obs_nblk]  = cyc;
          end
          obs_nblk++;
          hs_cyc = cyc;
        end
        tick();
      end
    end
    if (!fin) obs_timeout = 1;
    start = 1'b0;
    ks_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; ks_ready = 1'b0;
    key = '0; nonce = '0; counter_init = '0; num_blocks = '0;
    tick(); tick();
    n_cmp++;
    if ({ks_valid, busy, done, err_wrap} !== 4'b0) begin
      n_bad++; $display("FAIL reset_flags: got %b want 0000", {ks_valid, busy, done, err_wrap});
    end
    n_cmp++;
    if (ks_data !== '0 || ks_counter !== '0) begin
      n_bad++; $display("FAIL reset_ks: got ctr %h data %h want 0", ks_counter, ks_data);
    end
    n_cmp++;
    if (dr_state_o !== '0) begin
      n_bad++; $display("FAIL reset_dr_state: got %h want 0", dr_state_o);
    end
    reset_n = 1'b1;
    tick();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL idle_after_reset: busy got %b want 0", busy);
    end
  endtask

  task automatic test_rfc_vector();
    logic [255:0] k;
    logic [95:0]  n;
    for (int j = 0; j < 32; j++) k[8*j +: 8] = 8'(j);
    n = '0;
    n[31:24] = 8'h09;
    n[63:56] = 8'h4a;
    drive_job(k, n, 32'd1, BLK_W'(1), 1'b0, 1'b0);
    n_cmp++;
    if (obs_timeout != 0 || obs_nblk != 1) begin
      n_bad++; $display("FAIL rfc_blocks: got %0d blocks timeout %0d want 1 0", obs_nblk, obs_timeout);
    end
    n_cmp++;
    if (obs_busy1 !== 1'b1) begin
      n_bad++; $display("FAIL rfc_busy_rise: got %b want 1", obs_busy1);
    end
    n_cmp++;
    if (obs_first_valid != PERIOD) begin
      n_bad++; $display("FAIL rfc_latency: got %0d want %0d", obs_first_valid, PERIOD);
    end
    n_cmp++;
    if (obs_data[0][31:0] !== 32'he4e7f110 || obs_data[0][511:480] !== 32'h4e3c50a2) begin
      n_bad++; $display("FAIL rfc_words: got %h/%h want e4e7f110/4e3c50a2",
                        obs_data[0][31:0], obs_data[0][511:480]);
    end
    n_cmp++;
    if (obs_data[0] !== ref_block(k, n, 32'd1)) begin
      n_bad++; $display("FAIL rfc_block: got %h want %h", obs_data[0], ref_block(k, n, 32'd1));
    end
    n_cmp++;
    if (obs_ctr[0] !== 32'd1) begin
      n_bad++; $display("FAIL rfc_counter: got %h want 1", obs_ctr[0]);
    end
    n_cmp++;
    if (obs_done != 1 || obs_gap != 1 || obs_err != 0) begin
      n_bad++; $display("FAIL rfc_done: got done %0d gap %0d err %0d want 1 1 0", obs_done, obs_gap, obs_err);
    end
  endtask

  // Backpressure, plus start re-asserted with different inputs mid-job.
  task automatic test_backpressure();
    logic [255:0] k;
    logic [95:0]  n;
    logic [31:0]  c;
    k = rand256(); n = rand96(); c = 32'd7;
    drive_job(k, n, c, BLK_W'(4), 1'b1, 1'b1);
    n_cmp++;
    if (obs_timeout != 0 || obs_nblk != 4) begin
      n_bad++; $display("FAIL bp_blocks: got %0d timeout %0d want 4 0", obs_nblk, obs_timeout);
    end
    for (int i = 0; i < 4 && i < obs_nblk; i++) begin
      n_cmp++;
      if (obs_ctr[i] !== c + 32'(i)) begin
        n_bad++; $display("FAIL bp_counter%0d: got %h want %h", i, obs_ctr[i], c + 32'(i));
      end
      n_cmp++;
      if (obs_data[i] !== ref_block(k, n, c + 32'(i))) begin
        n_bad++; $display("FAIL bp_data%0d: got %h want %h", i, obs_data[i], ref_block(k, n, c + 32'(i)));
      end
    end
    n_cmp++;
    if (obs_unstable != 0) begin
      n_bad++; $display("FAIL bp_stall_stable: got %0d changes want 0", obs_unstable);
    end
    n_cmp++;
    if (obs_done != 1 || obs_err != 0 || obs_err_alone != 0) begin
      n_bad++; $display("FAIL bp_done: got done %0d err %0d want 1 0", obs_done, obs_err + obs_err_alone);
    end
  endtask

  task automatic test_counter_wrap();
    logic [255:0] k;
    logic [95:0]  n;
    k = rand256(); n = rand96();
    drive_job(k, n, 32'hFFFF_FFFE, BLK_W'(5), 1'b0, 1'b0);
    n_cmp++;
    if (obs_timeout != 0 || obs_nblk != 2) begin
      n_bad++; $display("FAIL wrap_blocks: got %0d timeout %0d want 2 0", obs_nblk, obs_timeout);
    end
    n_cmp++;
    if (obs_ctr[0] !== 32'hFFFF_FFFE || obs_ctr[1] !== 32'hFFFF_FFFF) begin
      n_bad++; $display("FAIL wrap_counters: got %h %h want fffffffe ffffffff", obs_ctr[0], obs_ctr[1]);
    end
    n_cmp++;
    if (obs_data[1] !== ref_block(k, n, 32'hFFFF_FFFF)) begin
      n_bad++; $display("FAIL wrap_data: got %h want %h", obs_data[1], ref_block(k, n, 32'hFFFF_FFFF));
    end
    n_cmp++;
    if (obs_cyc[1] - obs_cyc[0] != PERIOD) begin
      n_bad++; $display("FAIL wrap_period: got %0d want %0d", obs_cyc[1] - obs_cyc[0], PERIOD);
    end
    n_cmp++;
    if (obs_done != 1 || obs_err != 1 || obs_err_alone != 0 || obs_gap != 1) begin
      n_bad++; $display("FAIL wrap_flags: got done %0d err %0d lone %0d gap %0d want 1 1 0 1",
                        obs_done, obs_err, obs_err_alone, obs_gap);
    end
  endtask

  task automatic test_zero_blocks();
    drive_job(rand256(), rand96(), $urandom, '0, 1'b0, 1'b0);
    n_cmp++;
    if (obs_timeout != 0 || obs_valid_cycles != 0) begin
      n_bad++; $display("FAIL zero_valid: got %0d valid cycles timeout %0d want 0 0", obs_valid_cycles, obs_timeout);
    end
    n_cmp++;
    if (obs_done != 1 || obs_gap != 1 || obs_err != 0) begin
      n_bad++; $display("FAIL zero_done: got done %0d gap %0d err %0d want 1 1 0", obs_done, obs_gap, obs_err);
    end
  endtask

  task automatic test_abort();
    int           n_valid;
    bit           saw_done;
    logic [255:0] k2;
    logic [95:0]  n2;
    logic [31:0]  c2;
    key = rand256(); nonce = rand96(); counter_init = $urandom & 32'h7FFF_FFFF;
    num_blocks = BLK_W'(3); ks_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    n_valid = 0; saw_done = 0;
    // cycles 1..15: block 1 rounds, its OUT cycle (11), block 2 rounds 1..4
    for (int cyc = 1; cyc < PERIOD + 5; cyc++) begin
      if (done) saw_done = 1;
      if (ks_valid) n_valid++;
      tick();
    end
    n_cmp++;
    if (n_valid != 1 || busy !== 1'b1 || ks_valid !== 1'b0) begin
      n_bad++; $display("FAIL abort_setup: got valid %0d busy %b want 1 1", n_valid, busy);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    ks_ready = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || ks_valid !== 1'b0 || done !== 1'b0 || saw_done) begin
      n_bad++; $display("FAIL abort_idle: got busy %b valid %b done %b want 0 0 0", busy, ks_valid, done);
    end
    k2 = rand256(); n2 = rand96(); c2 = $urandom & 32'h7FFF_FFFF;
    drive_job(k2, n2, c2, BLK_W'(1), 1'b0, 1'b0);
    n_cmp++;
    if (obs_timeout != 0 || obs_nblk != 1 || obs_first_valid != PERIOD) begin
      n_bad++; $display("FAIL abort_restart: got blocks %0d first %0d want 1 %0d", obs_nblk, obs_first_valid, PERIOD);
    end
    n_cmp++;
    if (obs_ctr[0] !== c2 || obs_data[0] !== ref_block(k2, n2, c2)) begin
      n_bad++; $display("FAIL abort_new_block: got ctr %h want %h", obs_ctr[0], c2);
    end
    n_cmp++;
    if (obs_done != 1) begin
      n_bad++; $display("FAIL abort_new_done: got %0d want 1", obs_done);
    end
  endtask

  task automatic test_reset_mid_job();
    int waited;
    key = rand256(); nonce = rand96(); counter_init = $urandom;
    num_blocks = BLK_W'(2); ks_ready = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    waited = 0;
    while (!ks_valid && waited < 50) begin
      tick();
      waited++;
    end
    n_cmp++;
    if (ks_valid !== 1'b1) begin
      n_bad++; $display("FAIL midreset_reach_out: got %b want 1", ks_valid);
    end
    reset_n = 1'b0;
    tick();
    n_cmp++;
    if ({ks_valid, busy, done, err_wrap} !== 4'b0 || ks_data !== '0 || ks_counter !== '0 || dr_state_o !== '0) begin
      n_bad++; $display("FAIL midreset_outputs: got flags %b ctr %h want 0", {ks_valid, busy, done, err_wrap}, ks_counter);
    end
    reset_n = 1'b1;
    tick(); tick();
    n_cmp++;
    if (busy !== 1'b0 || ks_valid !== 1'b0) begin
      n_bad++; $display("FAIL midreset_no_resume: got busy %b valid %b want 0 0", busy, ks_valid);
    end
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; ks_ready = 1'b0;
    key = '0; nonce = '0; counter_init = '0; num_blocks = '0;
    test_reset();
    test_rfc_vector();
    test_backpressure();
    test_counter_wrap();
    test_zero_blocks();
    test_abort();
    test_reset_mid_job();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
